// File: rtl/uart_tx_if.sv
// uart_tx_if: word-load handshake and serial line bundle for uart_tx_fsm.
// master = SoC/bench side, slave = transmitter.
interface uart_tx_if #(
  parameter int MAX_DATA = 8,
  parameter int CNT_BITS = 14
);
  logic                tx_start;
  logic [MAX_DATA-1:0] tx_data;
  logic [3:0]          data_size;
  logic [CNT_BITS-1:0] bit_period;
  logic                serial_out;
  logic                tx_busy;
  logic                tx_done;

  modport master (
    output tx_start, tx_data, data_size, bit_period,
    input  serial_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_start, tx_data, data_size, bit_period,
    output serial_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmitter, start/data(LSB first)/stop framing.
// Ports: clk, n_rst (async low), tx (uart_tx_if.slave: load + serial line).
module uart_tx_fsm #(
  parameter int MAX_DATA = 8,
  parameter int CNT_BITS = 14
) (
  input  logic     clk,
  input  logic     n_rst,
  uart_tx_if.slave tx
);
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [3:0] MAX_SZ = 4'(MAX_DATA);
  localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_BITS-1:0] per_q, per_d;
  logic [3:0]          size_q, size_d;
  logic [3:0]          idx_q, idx_d;
  logic [MAX_DATA-1:0] sh_q, sh_d;
  logic                ser_q, ser_d;
  logic                done_q, done_d;
  logic                wrap;
  logic [3:0]          size_c;
  logic [CNT_BITS-1:0] per_c;

  assign wrap = (cnt_q == per_q);

  // Illegal configs are clamped once, when the frame is accepted.
  always_comb begin
    size_c = tx.data_size;
    if (tx.data_size == 4'd0)
      size_c = 4'd1;
    else if (tx.data_size > MAX_SZ)
      size_c = MAX_SZ;
    per_c = tx.bit_period;
    if (tx.bit_period == '0)
      per_c = ONE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      ser_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    size_d  = size_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      IDLE: begin
        if (tx.tx_start) begin
          state_d = START;
          cnt_d   = ONE;
          per_d   = per_c;
          size_d  = size_c;
          idx_d   = '0;
          sh_d    = tx.tx_data;
        end
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_d = ONE;
          if (idx_q == size_q - 4'd1) begin
            state_d = STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
            sh_d  = sh_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so it is registered
  // on the same edge that enters each bit.
  always_comb begin
    ser_d  = 1'b1;
    done_d = (state_q == STOP) && (state_d == IDLE);
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = sh_d[0];
      default: ser_d = 1'b1;
    endcase
  end

  assign tx.serial_out = ser_q;
  assign tx.tx_done    = done_q;
  assign tx.tx_busy    = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: directed checks of uart_tx_fsm framing and timing.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_uart_tx_fsm;
  logic clk;
  logic n_rst;
  int   checks;
  int   passed;

  uart_tx_if u_if ();

  uart_tx_fsm u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .tx    (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s got %0h exp %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [7:0] d, input logic [3:0] sz,
                       input logic [13:0] per);
    u_if.tx_data    = d;
    u_if.data_size  = sz;
    u_if.bit_period = per;
    u_if.tx_start   = 1'b1;
  endtask

  // Expected frame built from the effective (clamped) config.
  // rel: cycle index after which tx_start is dropped (-1 = never).
  task automatic frame_check(input logic [7:0] d, input int sz,
                             input int per, input int rel,
                             input string tag);
    int   n;
    int   b;
    logic e;
    n = (sz + 2) * per;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      b = k / per;
      if (b == 0)
        e = 1'b0;
      else if (b <= sz)
        e = d[b-1];
      else
        e = 1'b1;
      chk({tag, "_line"}, 32'(u_if.serial_out), 32'(e));
      chk({tag, "_busy"}, 32'(u_if.tx_busy), 32'd1);
      chk({tag, "_done0"}, 32'(u_if.tx_done), 32'd0);
      if (k == rel)
        u_if.tx_start = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_done1"}, 32'(u_if.tx_done), 32'd1);
    chk({tag, "_busy_end"}, 32'(u_if.tx_busy), 32'd0);
    chk({tag, "_line_end"}, 32'(u_if.serial_out), 32'd1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_idle_done"}, 32'(u_if.tx_done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(u_if.tx_busy), 32'd0);
    chk({tag, "_idle_line"}, 32'(u_if.serial_out), 32'd1);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    n_rst = 1'b0;
    u_if.tx_start   = 1'b0;
    u_if.tx_data    = '0;
    u_if.data_size  = 4'd8;
    u_if.bit_period = 14'd1;

    repeat (2) @(negedge clk);
    chk("rst_line", 32'(u_if.serial_out), 32'd1);
    chk("rst_busy", 32'(u_if.tx_busy), 32'd0);
    chk("rst_done", 32'(u_if.tx_done), 32'd0);
    n_rst = 1'b1;
    idle_check("post_rst");

    // 1: A5, 8 bits, 10 clk/bit
    drive(8'hA5, 4'd8, 14'd10);
    frame_check(8'hA5, 8, 10, 0, "t1");
    idle_check("t1");

    // 2: FF, 5 bits, 3 clk/bit
    drive(8'hFF, 4'd5, 14'd3);
    frame_check(8'hFF, 5, 3, 0, "t2");
    idle_check("t2");

    // 3: tx_start held across two frames
    drive(8'h00, 4'd8, 14'd4);
    frame_check(8'h00, 8, 4, -1, "t3a");
    frame_check(8'h00, 8, 4, 0, "t3b");
    idle_check("t3");

    // 4: request/config changes mid-frame are ignored
    drive(8'h3C, 4'd6, 14'd2);
    @(posedge clk);
    #1;
    u_if.tx_data    = 8'hFF;
    u_if.data_size  = 4'd2;
    u_if.bit_period = 14'd7;
    frame_check(8'h3C, 6, 2, 14, "t4");
    idle_check("t4");

    // 5: reset during data bit 3 (A5 bit3 = 0)
    drive(8'hA5, 4'd8, 14'd4);
    repeat (18) begin
      @(negedge clk);
      u_if.tx_start = 1'b0;
    end
    chk("t5_bit3", 32'(u_if.serial_out), 32'd0);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t5_rst_line", 32'(u_if.serial_out), 32'd1);
    chk("t5_rst_busy", 32'(u_if.tx_busy), 32'd0);
    chk("t5_rst_done", 32'(u_if.tx_done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_hold_done", 32'(u_if.tx_done), 32'd0);
    end
    n_rst = 1'b1;
    idle_check("t5_rel");
    drive(8'h5A, 4'd4, 14'd2);
    frame_check(8'h5A, 4, 2, 0, "t5n");
    idle_check("t5n");

    // 6: size 0 / period 0 clamp to 1 / 1
    drive(8'h01, 4'd0, 14'd0);
    frame_check(8'h01, 1, 1, 0, "t6");
    idle_check("t6");

    // oversize request clamps to 8 bits
    drive(8'h96, 4'd12, 14'd1);
    frame_check(8'h96, 8, 1, 0, "t7");
    idle_check("t7");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
